// File: rtl/calc_pkg.sv
// Shared types for the calculator core: sequencer states, decoded button and
// width helper for the iteration down-counter.
package calc_pkg;

  typedef enum logic [2:0] {
    XIdle,
    XMulIter,
    XDivIter,
    XDivFix,
    XWrite
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_EQU,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sm_to_tc.sv
// Signed-magnitude to two's complement conversion; a negative zero becomes 0.
module sm_to_tc #(
  parameter int W = 11
) (
  input  logic [W-1:0] sm,
  output logic [W-1:0] tc
);

  logic [W-1:0] mag;

  assign mag = {1'b0, sm[W-2:0]};
  assign tc  = sm[W-1] ? -mag : mag;

endmodule

// File: rtl/calc_engine.sv
// Sequential four-function calculator core holding the accumulator A.
// Booth multiply and restoring divide share one 2W+1-bit shift register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// XIdle    | sample buttons; Equals/Add/Subtract and divide-by-0 finish here
// XMulIter | one Booth step per cycle, W cycles
// XDivIter | one restoring-divide step per cycle, W cycles
// XDivFix  | apply quotient/remainder signs, detect quotient overflow
// XWrite   | write A, Remainder and flags
module calc_engine
  import calc_pkg::*;
#(
  parameter int W        = 11,
  parameter bit SM_INPUT = 1'b1
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Equals,
  input  logic         Add,
  input  logic         Subtract,
  input  logic         Multiply,
  input  logic         Divide,
  input  logic [W-1:0] Number,
  output logic [W-1:0] Result,
  output logic [W-1:0] Remainder,
  output logic         Overflow,
  output logic         DivByZero,
  output logic         Busy
);

  localparam int CW = cnt_width(W);

  logic [W-1:0] n_conv;

  generate
    if (SM_INPUT) begin : g_sm
      logic [W-1:0] n_tc;
      sm_to_tc #(.W(W)) u_sm_to_tc (.sm(Number), .tc(n_tc));
      assign n_conv = n_tc;
    end else begin : g_tc
      assign n_conv = Number;
    end
  endgenerate

  state_t       state, state_nx;
  op_t          op;
  logic [CW-1:0] cnt;
  // Multiply: {A_ext[W:0], Q[W-1:0]}; divide: {R[W:0], Q[W-1:0]}.
  logic [2*W:0] sr;
  logic         booth_q;
  logic [W-1:0] opnd;
  logic         is_div, q_neg, r_neg, div_ovf;
  logic [W-1:0] acc, rem;
  logic         ovf, dbz;

  logic [W-1:0] sum_add, sum_sub, a_mag, n_mag;
  logic [W:0]   m_ext, booth_sum, div_sh, div_trial;
  logic         prod_ovf;

  always_comb begin
    op = OP_NONE;
    if (Equals)        op = OP_EQU;
    else if (Add)      op = OP_ADD;
    else if (Subtract) op = OP_SUB;
    else if (Multiply) op = OP_MUL;
    else if (Divide)   op = OP_DIV;
  end

  always_ff @(posedge Clock) begin
    if (Clear) state <= XIdle;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = 1'b1;
    case (state)
      XIdle: begin
        Busy = 1'b0;
        if (op == OP_MUL)                        state_nx = XMulIter;
        else if (op == OP_DIV && n_conv != '0)   state_nx = XDivIter;
      end
      XMulIter: if (cnt == '0) state_nx = XWrite;
      XDivIter: if (cnt == '0) state_nx = XDivFix;
      XDivFix:  state_nx = XWrite;
      XWrite:   state_nx = XIdle;
      default:  state_nx = XIdle;
    endcase
  end

  assign sum_add  = acc + n_conv;
  assign sum_sub  = acc - n_conv;
  assign a_mag    = acc[W-1] ? -acc : acc;
  assign n_mag    = n_conv[W-1] ? -n_conv : n_conv;
  assign m_ext    = {opnd[W-1], opnd};
  assign div_sh   = sr[2*W-1:W-1];
  assign div_trial = div_sh - {1'b0, opnd};
  assign prod_ovf = sr[2*W:W] != {(W+1){sr[W-1]}};

  always_comb begin
    booth_sum = sr[2*W:W];
    case ({sr[0], booth_q})
      2'b01:   booth_sum = sr[2*W:W] + m_ext;
      2'b10:   booth_sum = sr[2*W:W] - m_ext;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      acc     <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      sr      <= '0;
      booth_q <= 1'b0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      div_ovf <= 1'b0;
    end else begin
      case (state)
        XIdle: begin
          case (op)
            OP_EQU: begin
              acc <= n_conv;
              ovf <= 1'b0;
              dbz <= 1'b0;
            end
            OP_ADD: begin
              acc <= sum_add;
              ovf <= (acc[W-1] == n_conv[W-1]) && (sum_add[W-1] != acc[W-1]);
              dbz <= 1'b0;
            end
            OP_SUB: begin
              acc <= sum_sub;
              ovf <= (acc[W-1] != n_conv[W-1]) && (sum_sub[W-1] != acc[W-1]);
              dbz <= 1'b0;
            end
            OP_MUL: begin
              sr      <= {{(W+1){1'b0}}, acc};
              booth_q <= 1'b0;
              opnd    <= n_conv;
              cnt     <= CW'(W - 1);
              is_div  <= 1'b0;
            end
            OP_DIV: begin
              if (n_conv == '0) begin
                dbz <= 1'b1;
                ovf <= 1'b0;
              end else begin
                sr     <= {{(W+1){1'b0}}, a_mag};
                opnd   <= n_mag;
                q_neg  <= acc[W-1] ^ n_conv[W-1];
                r_neg  <= acc[W-1];
                cnt    <= CW'(W - 1);
                is_div <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        XMulIter: begin
          sr      <= {booth_sum[W], booth_sum, sr[W-1:1]};
          booth_q <= sr[0];
          cnt     <= cnt - CW'(1);
        end
        XDivIter: begin
          if (!div_trial[W]) sr <= {div_trial, sr[W-2:0], 1'b1};
          else               sr <= {div_sh, sr[W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        XDivFix: begin
          sr[W-1:0]   <= q_neg ? -sr[W-1:0] : sr[W-1:0];
          sr[2*W:W]   <= {1'b0, r_neg ? -sr[2*W-1:W] : sr[2*W-1:W]};
          // Only a positive quotient of magnitude 2^(W-1) is unrepresentable.
          div_ovf     <= ~q_neg & sr[W-1];
        end
        XWrite: begin
          acc <= sr[W-1:0];
          dbz <= 1'b0;
          if (is_div) begin
            rem <= sr[2*W-1:W];
            ovf <= div_ovf;
          end else begin
            ovf <= prod_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result    = acc;
  assign Remainder = rem;
  assign Overflow  = ovf;
  assign DivByZero = dbz;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: a signed-magnitude and a two's-complement instance
// run side by side against an integer-arithmetic reference model.
module tb_calc_engine;

  localparam int W = 11;
  localparam logic [4:0] M_EQ  = 5'b10000;
  localparam logic [4:0] M_ADD = 5'b01000;
  localparam logic [4:0] M_SUB = 5'b00100;
  localparam logic [4:0] M_MUL = 5'b00010;
  localparam logic [4:0] M_DIV = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr, eq, add, sub, mul, dv;
  logic [W-1:0] num_s, num_t;
  logic [W-1:0] res_s, rem_s, res_t, rem_t;
  logic         ovf_s, dbz_s, busy_s, ovf_t, dbz_t, busy_t;

  calc_engine #(.W(W), .SM_INPUT(1'b1)) dut_sm (
    .Clock(clk), .Clear(clr), .Equals(eq), .Add(add), .Subtract(sub),
    .Multiply(mul), .Divide(dv), .Number(num_s), .Result(res_s),
    .Remainder(rem_s), .Overflow(ovf_s), .DivByZero(dbz_s), .Busy(busy_s)
  );

  calc_engine #(.W(W), .SM_INPUT(1'b0)) dut_tc (
    .Clock(clk), .Clear(clr), .Equals(eq), .Add(add), .Subtract(sub),
    .Multiply(mul), .Divide(dv), .Number(num_t), .Result(res_t),
    .Remainder(rem_t), .Overflow(ovf_t), .DivByZero(dbz_t), .Busy(busy_t)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = signed-magnitude instance, 1 = two's complement.
  int m_acc[2], m_rem[2];
  int m_ovf[2], m_dbz[2];

  function automatic int wrap(input int x);
    int y;
    y = x & ((1 << W) - 1);
    if (y >= (1 << (W - 1))) y -= (1 << W);
    return y;
  endfunction

  function automatic int fits(input int x);
    return (x >= -(1 << (W - 1)) && x <= (1 << (W - 1)) - 1) ? 1 : 0;
  endfunction

  function automatic int dec(input int d, input logic [W-1:0] raw);
    int v;
    if (d == 0) begin
      v = int'(raw[W-2:0]);
      if (raw[W-1]) v = -v;
    end else begin
      v = int'($signed(raw));
    end
    return v;
  endfunction

  function automatic logic [W-1:0] enc_sm(input int v);
    logic [W-1:0] r;
    r = W'(v < 0 ? -v : v);
    if (v < 0) r[W-1] = 1'b1;
    return r;
  endfunction

  function automatic int pick(input logic [4:0] m);
    if (m[4]) return 1;
    if (m[3]) return 2;
    if (m[2]) return 3;
    if (m[1]) return 4;
    if (m[0]) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 0; m_rem[d] = 0; m_ovf[d] = 0; m_dbz[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input int opc, input int v, output int bz);
    int t;
    bz = 0;
    case (opc)
      1: begin m_acc[d] = v; m_ovf[d] = 0; m_dbz[d] = 0; end
      2: begin t = m_acc[d] + v; m_acc[d] = wrap(t); m_ovf[d] = !fits(t); m_dbz[d] = 0; end
      3: begin t = m_acc[d] - v; m_acc[d] = wrap(t); m_ovf[d] = !fits(t); m_dbz[d] = 0; end
      4: begin t = m_acc[d] * v; m_acc[d] = wrap(t); m_ovf[d] = !fits(t); m_dbz[d] = 0; bz = W + 1; end
      5: begin
        if (v == 0) begin
          m_dbz[d] = 1; m_ovf[d] = 0;
        end else begin
          t = m_acc[d] / v;
          m_rem[d] = m_acc[d] % v;
          m_acc[d] = wrap(t); m_ovf[d] = !fits(t); m_dbz[d] = 0; bz = W + 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare(input string tag);
    check({tag, " sm result"},  int'($signed(res_s)), m_acc[0]);
    check({tag, " sm rem"},     int'($signed(rem_s)), m_rem[0]);
    check({tag, " sm ovf"},     int'(ovf_s), m_ovf[0]);
    check({tag, " sm dbz"},     int'(dbz_s), m_dbz[0]);
    check({tag, " tc result"},  int'($signed(res_t)), m_acc[1]);
    check({tag, " tc rem"},     int'($signed(rem_t)), m_rem[1]);
    check({tag, " tc ovf"},     int'(ovf_t), m_ovf[1]);
    check({tag, " tc dbz"},     int'(dbz_t), m_dbz[1]);
  endtask

  // inject: busy cycle index at which Equals+Add are pulsed (-1 = none)
  // abort_at: busy cycle index at which Clear is pulsed (-1 = none)
  task automatic press(input string tag, input logic [4:0] mask,
                       input logic [W-1:0] ns, input logic [W-1:0] nt,
                       input int inject, input int abort_at);
    int bz0, bz1, c0, c1, p0, p1, opc;
    bit aborted;
    p0 = m_acc[0]; p1 = m_acc[1];
    aborted = 1'b0; c0 = 0; c1 = 0;
    @(negedge clk);
    {eq, add, sub, mul, dv} = mask;
    num_s = ns; num_t = nt;
    @(posedge clk); #1;
    {eq, add, sub, mul, dv} = '0;
    num_s = W'($urandom); num_t = W'($urandom);
    opc = pick(mask);
    model_step(0, opc, dec(0, ns), bz0);
    model_step(1, opc, dec(1, nt), bz1);
    for (int k = 0; k < 40 && (busy_s || busy_t); k++) begin
      if (busy_s) c0++;
      if (busy_t) c1++;
      if (k == 2) begin
        if (busy_s) check({tag, " sm hold"}, int'($signed(res_s)), p0);
        if (busy_t) check({tag, " tc hold"}, int'($signed(res_t)), p1);
      end
      if (k == inject && busy_s && busy_t) begin eq = 1'b1; add = 1'b1; end
      if (k == abort_at) clr = 1'b1;
      @(posedge clk); #1;
      eq = 1'b0; add = 1'b0;
      if (clr) begin clr = 1'b0; aborted = 1'b1; break; end
    end
    if (busy_s || busy_t)
      check({tag, " busy timeout"}, int'(busy_s | busy_t), 0);
    if (aborted) begin
      model_reset();
      check({tag, " abort busy"}, int'(busy_s | busy_t), 0);
      compare({tag, " abort"});
      @(posedge clk); #1;
      check({tag, " abort idle"}, int'(busy_s | busy_t), 0);
    end else begin
      check({tag, " sm busy cycles"}, c0, bz0);
      check({tag, " tc busy cycles"}, c1, bz1);
      compare(tag);
    end
  endtask

  task automatic op(input string tag, input logic [4:0] mask, input int v);
    press(tag, mask, enc_sm(v), W'(v), -1, -1);
  endtask

  initial begin
    logic [4:0] mask;
    logic [W-1:0] ns, nt;
    int inj, abt;
    clr = 1'b1; {eq, add, sub, mul, dv} = '0; num_s = '0; num_t = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset");
    check("reset busy", int'(busy_s | busy_t), 0);
    clr = 1'b0;

    op("eq5", M_EQ, 5);
    op("add-3", M_ADD, -3);
    check("spec add", int'($signed(res_s)), 2);
    op("eq1000", M_EQ, 1000);
    op("add100", M_ADD, 100);
    check("spec add ovf", int'($signed(res_s)), -948);
    op("eq7", M_EQ, 7);
    op("eq-25", M_EQ, -25);
    op("mul40", M_MUL, 40);
    check("spec mul", int'($signed(res_s)), -1000);
    op("mul2", M_MUL, 2);
    check("spec mul ovf", int'($signed(res_s)), 48);
    op("eq-100", M_EQ, -100);
    op("div7", M_DIV, 7);
    check("spec div rem", int'($signed(rem_s)), -2);
    op("div0", M_DIV, 0);
    op("eq1023", M_EQ, 1023);
    op("add1", M_ADD, 1);
    op("div-1", M_DIV, -1);
    press("eq0x400", M_EQ, W'(11'h400), W'(11'h400), -1, -1);
    op("tc div-1", M_DIV, -1);
    check("spec tc div ovf", int'(ovf_t), 1);
    op("eq9", M_EQ, 9);
    op("add+sub", M_ADD | M_SUB, 4);
    op("mul+div", M_MUL | M_DIV, 3);
    op("eq300", M_EQ, 300);
    press("mul abort", M_MUL, enc_sm(5), W'(5), -1, 4);
    op("eq-25b", M_EQ, -25);
    press("mul inject", M_MUL, enc_sm(40), W'(40), 3, -1);
    check("spec inject", int'($signed(res_s)), -1000);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) mask = 5'($urandom);
      else                           mask = 5'b1 << $urandom_range(0, 4);
      ns = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      nt = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      abt = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 10)) : -1;
      press("rand", mask, ns, nt, inj, abt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
